// File: rtl/async_fifo_dc.sv
// Dual-clock FIFO: Gray-coded pointers crossing through configurable synchroniser chains,
// with registered full/empty, almost flags, per-side fill counts and overflow/underflow pulses.
`timescale 1ns/1ps
module async_fifo_dc #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_SIZE   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6,
    parameter int AE_THRESH   = 1
) (
    input  logic                  rd_clk,
    input  logic                  wr_clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_SIZE:0]    wr_count,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_SIZE:0]    rd_count,
    output logic                  underflow
);
    localparam int A     = ADDR_SIZE;
    localparam int DEPTH = 1 << A;
    localparam logic [A:0] AF_T = (A+1)'(AF_THRESH);
    localparam logic [A:0] AE_T = (A+1)'(AE_THRESH);

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write domain
    logic [A:0] r_wbin, r_wgray;
    logic [SYNC_STAGES-1:0][A:0] r_rgray_sync;
    logic [A:0] w_wbin_next, w_wgray_next, w_rgray_s, w_wcount_next;
    logic       w_wr;

    // Read domain
    logic [A:0] r_rbin, r_rgray;
    logic [SYNC_STAGES-1:0][A:0] r_wgray_sync;
    logic [A:0] w_rbin_next, w_rgray_next, w_wgray_s, w_rcount_next;
    logic       w_rd;

    assign w_wr          = wr_en && !full;
    assign w_wbin_next   = r_wbin + (A+1)'(w_wr);
    assign w_wgray_next  = (w_wbin_next >> 1) ^ w_wbin_next;
    assign w_rgray_s     = r_rgray_sync[SYNC_STAGES-1];
    assign w_wcount_next = w_wbin_next - gray2bin(w_rgray_s);

    always_ff @(posedge wr_clk) begin
        if (w_wr) r_mem[r_wbin[A-1:0]] <= wr_data;
    end

    // Flags and count are computed from the post-write pointer so full rises on the filling write.
    always_ff @(posedge wr_clk or posedge clr) begin
        if (clr) begin
            r_wbin       <= '0;
            r_wgray      <= '0;
            r_rgray_sync <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            wr_count     <= '0;
            overflow     <= 1'b0;
        end else begin
            r_wbin       <= w_wbin_next;
            r_wgray      <= w_wgray_next;
            r_rgray_sync <= {r_rgray_sync[SYNC_STAGES-2:0], r_rgray};
            full         <= (w_wgray_next == {~w_rgray_s[A:A-1], w_rgray_s[A-2:0]});
            almost_full  <= (w_wcount_next >= AF_T);
            wr_count     <= w_wcount_next;
            overflow     <= wr_en && full;
        end
    end

    assign w_rd          = rd_en && !empty;
    assign w_rbin_next   = r_rbin + (A+1)'(w_rd);
    assign w_rgray_next  = (w_rbin_next >> 1) ^ w_rbin_next;
    assign w_wgray_s     = r_wgray_sync[SYNC_STAGES-1];
    assign w_rcount_next = gray2bin(w_wgray_s) - w_rbin_next;

    always_ff @(posedge rd_clk or posedge clr) begin
        if (clr) begin
            r_rbin       <= '0;
            r_rgray      <= '0;
            r_wgray_sync <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            r_rbin       <= w_rbin_next;
            r_rgray      <= w_rgray_next;
            r_wgray_sync <= {r_wgray_sync[SYNC_STAGES-2:0], r_wgray};
            if (w_rd) rd_data <= r_mem[r_rbin[A-1:0]];
            rd_valid     <= w_rd;
            empty        <= (w_rgray_next == w_wgray_s);
            almost_empty <= (w_rcount_next <= AE_T);
            rd_count     <= w_rcount_next;
            underflow    <= rd_en && empty;
        end
    end
endmodule
